// File: rtl/tick_pkg.sv
// Shared types and defaults for the 1 s tick receiver.
// Holds the state encoding, default parameters and the move threshold helper.
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } tick_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_WDOG_MAX    = 60000000;

    // A speed of 0 behaves like 1 so a move is never starved.
    function automatic logic [4:0] move_threshold(input logic [3:0] speed);
        return (speed == 4'd0) ? 5'd1 : {1'b0, speed};
    endfunction

endpackage

// File: rtl/tick_receiver_sync_edge.sv
// Synchronizer chain plus history flop for the asynchronous tick_in.
// tick_edge is a registered one-cycle strobe for each toggle of din.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick_edge
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   edge_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            hist_reg <= sync_reg[SYNC_STAGES-1];
            edge_reg <= sync_reg[SYNC_STAGES-1] ^ hist_reg;
        end
    end

    assign tick_edge = edge_reg;

endmodule

// File: rtl/tick_receiver.sv
// Seconds tick receiver: counts synchronized tick_in edges, paces game moves
// with a req/ack handshake, and flags a lost tick source via a watchdog.
module tick_receiver
    import tick_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int WDOG_MAX    = DEFAULT_WDOG_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        enable,
    input  logic [3:0]  speed,
    input  logic        move_ack,
    output logic        tick_pulse,
    output logic        move_req,
    output logic [15:0] sec_count,
    output logic        tick_lost,
    output logic        overrun
);

    localparam int WDOG_W = $clog2(WDOG_MAX + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX);

    logic              tick_edge;
    tick_state_t       state_reg, state_next;
    logic              tick_pulse_reg;
    logic              move_req_reg, move_req_next;
    logic              overrun_reg, overrun_next;
    logic [15:0]       sec_count_reg, sec_count_next;
    logic [3:0]        div_cnt_reg, div_cnt_next;
    logic [WDOG_W-1:0] wdog_reg, wdog_next;
    logic              active;
    logic              move_event;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .din      (tick_in),
        .tick_edge(tick_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            tick_pulse_reg <= 1'b0;
            move_req_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            sec_count_reg  <= 16'd0;
            div_cnt_reg    <= 4'd0;
            wdog_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            tick_pulse_reg <= tick_edge;
            move_req_reg   <= move_req_next;
            overrun_reg    <= overrun_next;
            sec_count_reg  <= sec_count_next;
            div_cnt_reg    <= div_cnt_next;
            wdog_reg       <= wdog_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        move_req_next  = move_req_reg;
        overrun_next   = overrun_reg;
        sec_count_next = sec_count_reg;
        div_cnt_next   = div_cnt_reg;
        wdog_next      = wdog_reg;
        move_event     = 1'b0;
        // Dropping enable takes effect immediately, not after the IDLE transition.
        active         = enable && (state_reg != IDLE);

        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     if (wdog_reg == WDOG_LIMIT && !tick_edge) state_next = STALL;
                STALL:   if (tick_edge) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end

        if (!active) begin
            div_cnt_next  = 4'd0;
            wdog_next     = '0;
            move_req_next = 1'b0;
        end else begin
            if (tick_edge) begin
                sec_count_next = sec_count_reg + 16'd1;
                wdog_next      = '0;
                // Compare at 5 bits so a lowered speed still fires on the next edge.
                if ({1'b0, div_cnt_reg} + 5'd1 >= move_threshold(speed)) begin
                    div_cnt_next = 4'd0;
                    move_event   = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + 4'd1;
                end
            end else if (wdog_reg != WDOG_LIMIT) begin
                wdog_next = wdog_reg + WDOG_W'(1);
            end

            if (move_event) begin
                move_req_next = 1'b1;
                if (move_req_reg && !move_ack) overrun_next = 1'b1;
            end else if (move_ack && move_req_reg) begin
                move_req_next = 1'b0;
            end
        end
    end

    assign tick_pulse = tick_pulse_reg;
    assign move_req   = move_req_reg;
    assign sec_count  = sec_count_reg;
    assign tick_lost  = (state_reg == STALL);
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_tick_receiver.sv
// Directed bench for tick_receiver with a sec_count scoreboard queue.
module tb_tick_receiver;

    localparam int SYNC = 2;
    localparam int WMAX = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        move_ack = 1'b0;
    logic        tick_pulse;
    logic        move_req;
    logic [15:0] sec_count;
    logic        tick_lost;
    logic        overrun;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_sec = 16'd0;
    logic [15:0] sb[$];

    tick_receiver #(
        .SYNC_STAGES(SYNC),
        .WDOG_MAX   (WMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .enable    (enable),
        .speed     (speed),
        .move_ack  (move_ack),
        .tick_pulse(tick_pulse),
        .move_req  (move_req),
        .sec_count (sec_count),
        .tick_lost (tick_lost),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Toggle tick_in, then wait (bounded) for the pulse and score sec_count.
    task automatic send_edge(input string tag, input logic counted);
        logic        got;
        logic [15:0] want;
        int          n;
        if (counted) exp_sec = exp_sec + 16'd1;
        sb.push_back(exp_sec);
        @(negedge clk);
        tick_in = ~tick_in;
        got = 1'b0;
        n = 0;
        while (!got && n < 10) begin
            cycle();
            n = n + 1;
            if (tick_pulse) got = 1'b1;
        end
        check({tag, "_pulse"}, 32'(got), 32'd1);
        want = sb.pop_front();
        if (got) check({tag, "_sec"}, 32'(sec_count), 32'(want));
        $display("edge %s: tick_in=%0b sec_count=%0d move_req=%0b overrun=%0b tick_lost=%0b",
                 tag, tick_in, sec_count, move_req, overrun, tick_lost);
    endtask

    task automatic ack_move(input string tag);
        cycle();
        @(negedge clk);
        move_ack = 1'b1;
        cycle();
        check({tag, "_ack_clear"}, 32'(move_req), 32'd0);
        @(negedge clk);
        move_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        int pulses;
        logic exp_move;

        // Reset state
        repeat (3) cycle();
        check("reset_state", 32'({tick_pulse, move_req, tick_lost, overrun, sec_count}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        speed = 4'd3;
        enable = 1'b1;
        repeat (3) cycle();
        check("post_reset", 32'({tick_pulse, move_req, tick_lost, overrun, sec_count}), 32'd0);

        // Latency: pulse exactly 3 cycles after the sampling edge
        @(negedge clk);
        tick_in = 1'b1;
        cycle();
        check("lat_k0", 32'(tick_pulse), 32'd0);
        cycle();
        check("lat_k1", 32'(tick_pulse), 32'd0);
        cycle();
        check("lat_k2", 32'(tick_pulse), 32'd0);
        check("lat_sec_before", 32'(sec_count), 32'd0);
        cycle();
        check("lat_k3", 32'(tick_pulse), 32'd1);
        check("lat_sec_after", 32'(sec_count), 32'd1);
        cycle();
        check("lat_k4", 32'(tick_pulse), 32'd0);
        exp_sec = 16'd1;
        $display("latency: sec_count=%0d", sec_count);

        // Pass through IDLE to clear div_cnt
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) cycle();

        // Divider: speed=3, moves after edges 3, 6, 9
        for (int e = 1; e <= 9; e++) begin
            send_edge($sformatf("div%0d", e), 1'b1);
            exp_move = (e == 3 || e == 6 || e == 9);
            check($sformatf("div%0d_move", e), 32'(move_req), 32'(exp_move));
            if (exp_move) ack_move($sformatf("div%0d", e));
        end
        check("div_overrun", 32'(overrun), 32'd0);

        // Watchdog
        cnt = 2;
        while (!tick_lost && cnt < 200) begin
            cycle();
            cnt = cnt + 1;
            if (cnt == 60) check("wdog_early", 32'(tick_lost), 32'd0);
        end
        check("wdog_fire", 32'(tick_lost), 32'd1);
        check("wdog_timing", 32'(cnt >= 99 && cnt <= 103), 32'd1);
        $display("watchdog: tick_lost after %0d cycles", cnt);
        repeat (5) cycle();
        check("wdog_hold", 32'(tick_lost), 32'd1);
        send_edge("wdog_edge", 1'b1);
        check("wdog_clear", 32'(tick_lost), 32'd0);
        check("wdog_nomove", 32'(move_req), 32'd0);

        // Wrap and IDLE behaviour
        @(negedge clk);
        speed = 4'd1;
        force dut.sec_count_reg = 16'hFFFF;
        cycle();
        @(negedge clk);
        release dut.sec_count_reg;
        cycle();
        exp_sec = 16'hFFFF;
        check("preload", 32'(sec_count), 32'h0000FFFF);
        send_edge("wrap", 1'b1);
        check("wrap_move", 32'(move_req), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        cycle();
        check("idle_move_drop", 32'(move_req), 32'd0);
        send_edge("idle_edge", 1'b0);
        check("idle_lost", 32'(tick_lost), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        repeat (2) cycle();

        // Overrun and coincident ack
        send_edge("ovr_a", 1'b1);
        check("ovr_a_move", 32'(move_req), 32'd1);
        check("ovr_a_overrun", 32'(overrun), 32'd0);
        exp_sec = exp_sec + 16'd1;
        sb.push_back(exp_sec);
        @(negedge clk);
        tick_in = ~tick_in;
        repeat (3) @(negedge clk);
        move_ack = 1'b1;
        cycle();
        check("ovr_b_pulse", 32'(tick_pulse), 32'd1);
        check("ovr_b_sec", 32'(sec_count), 32'(sb.pop_front()));
        check("ovr_b_move", 32'(move_req), 32'd1);
        check("ovr_b_overrun", 32'(overrun), 32'd0);
        $display("edge ovr_b: coincident ack move_req=%0b overrun=%0b", move_req, overrun);
        @(negedge clk);
        move_ack = 1'b0;
        send_edge("ovr_c", 1'b1);
        check("ovr_c_move", 32'(move_req), 32'd1);
        check("ovr_c_overrun", 32'(overrun), 32'd1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        tick_in = 1'b1;
        #1;
        check("async_rst", 32'({tick_pulse, move_req, tick_lost, overrun, sec_count}), 32'd0);
        $display("async reset: move_req=%0b overrun=%0b sec_count=%0d", move_req, overrun, sec_count);
        repeat (2) cycle();
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tick_pulse) pulses = pulses + 1;
        end
        check("release_artefact", 32'(pulses), 32'd1);
        check("release_sec", 32'(sec_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tick_receiver.md
TICK_RECEIVER -- requirements
Module: tick_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, which is the synchronizer depth for tick_in (minimum 2).
REQ-002 SHALL have parameter WDOG_MAX, default 60000000, which is the clk cycles without a tick_in edge before tick_lost asserts.
REQ-003 SHALL have port clk, input, 1 bit: system clock; the single clock domain.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port tick_in, input, 1 bit: toggling slow clock from the 1 s divider; each edge is one second; asynchronous to clk.
REQ-006 SHALL have port enable, input, 1 bit: run control; low forces IDLE.
REQ-007 SHALL have port speed, input, 4 bits: seconds per game move; 0 is treated as 1.
REQ-008 SHALL have port move_ack, input, 1 bit: consumer acknowledge for move_req.
REQ-009 SHALL have port tick_pulse, output, 1 bit: one-cycle pulse per synchronized tick_in edge.
REQ-010 SHALL have port move_req, output, 1 bit: move request, level, held until acknowledged.
REQ-011 SHALL have port sec_count, output, 16 bits: elapsed seconds while enabled.
REQ-012 SHALL have port tick_lost, output, 1 bit: watchdog flag.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag; a move event occurred while move_req was pending.

Function
REQ-014 SHALL pass tick_in through a SYNC_STAGES flop chain, then one edge-history flop; edge = last sync stage XOR history flop.
REQ-015 SHALL register tick_pulse, so it is high exactly SYNC_STAGES+1 clk cycles after the first rising clk edge that samples the new tick_in level.
REQ-016 SHALL produce tick_pulse for both rising and falling tick_in edges, regardless of enable or state.
REQ-017 SHALL use FSM states IDLE, RUN and STALL; IDLE goes to RUN when enable=1; RUN goes to STALL when the watchdog reaches WDOG_MAX; STALL goes to RUN on the next edge; any state goes to IDLE when enable=0.
REQ-018 SHALL, in IDLE, clear div_cnt, the watchdog and move_req, and freeze sec_count; overrun is unchanged.
REQ-019 SHALL, in RUN or STALL, increment sec_count by 1 on each tick_pulse, with modulo-2^16 wrap (65535 goes to 0).
REQ-020 SHALL count edges in div_cnt (4 bits) in RUN/STALL; when div_cnt+1 >= max(speed,1), clear div_cnt and raise a move event; otherwise increment div_cnt.
REQ-021 SHALL apply a speed change at the next edge; if div_cnt already >= the new threshold, the next edge raises a move event.
REQ-022 SHALL set move_req on a move event and clear it on the cycle move_ack=1 is sampled with move_req=1; move_ack is ignored when move_req=0.
REQ-023 SHALL, when a move event and a valid ack occur in the same cycle, keep move_req=1 and leave overrun unset.
REQ-024 SHALL, on a move event with move_req=1 and no ack, keep move_req=1 and set overrun=1 until rst.
REQ-025 SHALL clear the watchdog counter on every edge and otherwise increment it, saturating at WDOG_MAX, only in RUN/STALL.
REQ-026 SHALL drive tick_lost=1 exactly while in STALL; the edge that leaves STALL is also counted normally (sec_count, div_cnt).
REQ-027 SHALL produce edges for each toggle without merging, provided tick_in toggles no faster than once per SYNC_STAGES+2 clk cycles; faster toggling is outside specification.

Reset
REQ-028 SHALL, while rst=1, set all flops asynchronously: sync chain and history flop to 0, state IDLE, tick_pulse 0, move_req 0, sec_count 0, div_cnt 0, watchdog 0, tick_lost 0, overrun 0.
REQ-029 SHALL, if tick_in=1 at reset release, produce exactly one tick_pulse after SYNC_STAGES+1 cycles, which is the accepted artefact of a zero-reset sync chain.
REQ-030 SHALL, on rst mid-request, drop move_req immediately with no ack required.

Structure
REQ-031 SHALL place the state enum (IDLE/RUN/STALL) and the default WDOG_MAX and SYNC_STAGES constants in shared package tick_pkg.
REQ-032 SHALL instantiate one sub-module, sync_edge (synchronizer, history flop, edge output); all remaining logic stays in tick_receiver.

Verification
REQ-033 SHALL verify latency: with SYNC_STAGES=2 and enable=1, one tick_in toggle produces one tick_pulse exactly 3 cycles after the sampling edge and sec_count goes 0 to 1.
REQ-034 SHALL verify the divider and handshake: speed=3 and 7 edges give move_req after edges 3 and 6; ack 2 cycles later clears it; div_cnt=1 at the end; overrun=0.
REQ-035 SHALL verify overrun: speed=1, no ack over 2 edges gives move_req=1 and overrun=1; ack in the same cycle as an edge keeps move_req=1.
REQ-036 SHALL verify the watchdog: WDOG_MAX=100, no edge for 100 cycles gives tick_lost=1; the next edge gives tick_lost=0 one cycle later and sec_count increments.
REQ-037 SHALL verify wrap and IDLE: sec_count preloaded via 65535 edges, one more edge gives 0; enable=0 mid-request gives move_req=0 next cycle and sec_count frozen while tick_pulse still pulses.
REQ-038 SHALL verify async reset: rst asserted mid-cycle while move_req=1 and overrun=1 clears all outputs before the next clk edge.
